noc_out_pkt_fifo: RTL
=====================

NOC_OUT_PKT_FIFO -- requirements
Module: noc_out_pkt_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning FIFO capacity in 32-bit words; power of two, >= 4.
REQ-002 The block SHALL have parameter ADDR_W, default $clog2(DEPTH), meaning pointer width.
REQ-003 The block SHALL have port clk_line, input, 1, the single clock; all logic SHALL be on its rising edge.
REQ-004 The block SHALL have port clk_line_rst_high, input, 1, the reset, which SHALL be synchronous and active-high.
REQ-005 The block SHALL have ports stream_in_TVALID, TDATA[31:0], TKEEP[3:0] and TLAST as inputs: the word stream from the NoC output arbiter.
REQ-006 The block SHALL have port stream_in_TREADY, output, 1, meaning a word is accepted when TVALID and TREADY are both high.
REQ-007 The block SHALL have ports stream_out_TVALID, TDATA[31:0], TKEEP[3:0] and TLAST as outputs: the word stream to the NoC router port.
REQ-008 The block SHALL have port stream_out_TREADY, input, 1, meaning a word is consumed when TVALID and TREADY are both high.
REQ-009 The block SHALL have port fifo_count, output, ADDR_W+1, meaning words currently stored.
REQ-010 The block SHALL have port pkt_count, output, ADDR_W+1, meaning complete packets stored (TLAST written, not yet read).
REQ-011 The block SHALL have port release_mode, output, 1, meaning cut-through release is active because an oversize packet filled the FIFO.

Function
REQ-012 Storage SHALL be DEPTH entries of {TDATA, TLAST}; input TKEEP SHALL be ignored and stream_out_TKEEP SHALL be constant 4'b1111.
REQ-013 stream_in_TREADY SHALL equal (fifo_count != DEPTH), decoded from registered state with no combinational path from any input.
REQ-014 Write and read pointers SHALL be ADDR_W bits, advance by one per transfer, and wrap from DEPTH-1 to 0.
REQ-015 fifo_count SHALL be +1 on write only, -1 on read only, and unchanged on simultaneous write and read.
REQ-016 pkt_count SHALL be +1 on a write with TLAST=1, -1 on a read with TLAST=1, and unchanged when both happen in the same cycle.
REQ-017 stream_out_TVALID SHALL equal (fifo_count != 0) AND (pkt_count != 0 OR release_mode), which is store-and-forward.
REQ-018 stream_out_TDATA and TLAST SHALL show the entry at the read pointer (first-word-fall-through) and SHALL hold stable while TVALID=1 and TREADY=0.
REQ-019 Latency: the last word of a packet accepted at edge N SHALL make the packet's first word valid on the output after edge N (one cycle).
REQ-020 Words of an incomplete packet SHALL NOT be presented while pkt_count=0 and release_mode=0.
REQ-021 release_mode SHALL set at the edge where fifo_count becomes DEPTH while pkt_count is 0, including when a write fills the FIFO and a read occurs in the same cycle.
REQ-022 release_mode SHALL clear at the edge where a word with TLAST=1 is read; if set and clear coincide, clear SHALL win.
REQ-023 While release_mode=1, packets behind the oversize one SHALL still follow REQ-017 once release_mode clears.
REQ-024 When fifo_count=DEPTH, input words SHALL be back-pressured, never dropped or overwritten.
REQ-025 When fifo_count=0, no read SHALL occur, whatever the value of stream_out_TREADY.
REQ-026 Word order SHALL be preserved exactly, and packet boundaries (TLAST) SHALL be preserved one-to-one.

Reset
REQ-027 While clk_line_rst_high=1 at an edge, the pointers, fifo_count, pkt_count and release_mode SHALL be cleared to 0.
REQ-028 During and immediately after reset, stream_out_TVALID SHALL be 0 and stream_in_TREADY SHALL be 1.
REQ-029 Reset asserted mid-packet SHALL discard all stored words, including partial packets; the memory array SHALL NOT need a reset.

Verification
REQ-030 Send 3 words A0,A1,A2 (TLAST on A2) with out_TREADY=1 -> out_TVALID=0 while A0 and A1 are held; A0..A2 emitted starting the cycle after A2 is accepted; pkt_count 1 then 0.
REQ-031 With DEPTH=16 and out_TREADY=0, send packets of 4 and 5 words -> fifo_count=9, pkt_count=2; then raise TREADY -> 9 words out in order with TLAST on words 4 and 9.
REQ-032 Send a 20-word packet with DEPTH=16 and out_TREADY=1 after the FIFO fills -> in_TREADY=0 at fifo_count=16; release_mode=1; all 20 words delivered; release_mode=0 after word 20 is read.
REQ-033 Continuous 1-word packets with in_TVALID=1 and out_TREADY=1 -> throughput of 1 word/cycle after the first; fifo_count steady at 1; pkt_count never exceeds 1.
REQ-034 Randomised TREADY on both sides for 10000 words across pointer wraps -> output order and TLAST positions match a scoreboard; TDATA stable while stalled.
REQ-035 Assert reset after 2 words of a 4-word packet -> fifo_count=0, pkt_count=0, out_TVALID=0 the cycle after; a new 1-word packet then passes normally.

Source files
------------

// File: rtl/noc_out_pkt_fifo.sv
// NoC output packet FIFO: store-and-forward buffer of {TDATA, TLAST} words, with a
// cut-through release mode used when one packet is larger than the whole buffer.
module noc_out_pkt_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_line,
  input  logic              clk_line_rst_high,
  input  logic              stream_in_TVALID,
  input  logic [31:0]       stream_in_TDATA,
  input  logic [3:0]        stream_in_TKEEP,
  input  logic              stream_in_TLAST,
  output logic              stream_in_TREADY,
  output logic              stream_out_TVALID,
  output logic [31:0]       stream_out_TDATA,
  output logic [3:0]        stream_out_TKEEP,
  output logic              stream_out_TLAST,
  input  logic              stream_out_TREADY,
  output logic [ADDR_W:0]   fifo_count,
  output logic [ADDR_W:0]   pkt_count,
  output logic              release_mode
);

  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [32:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_next;
  logic [ADDR_W:0]   pkt_next;
  logic              release_next;
  logic              wr_en;
  logic              rd_en;
  logic              wr_last;
  logic              rd_last;
  logic              unused_keep;

  // Input keep is not stored; every word on the output is a full 32-bit word.
  assign unused_keep      = ^stream_in_TKEEP;
  assign stream_out_TKEEP = 4'b1111;

  assign stream_in_TREADY  = (fifo_count != FULL_CNT);
  assign stream_out_TVALID = (fifo_count != '0) && ((pkt_count != '0) || release_mode);
  assign {stream_out_TLAST, stream_out_TDATA} = mem[rd_ptr];

  assign wr_en   = stream_in_TVALID && stream_in_TREADY;
  assign rd_en   = stream_out_TVALID && stream_out_TREADY;
  assign wr_last = wr_en && stream_in_TLAST;
  assign rd_last = rd_en && stream_out_TLAST;

  // A full buffer holding no complete packet can only drain by releasing the
  // oversize packet early; leaving release on its TLAST restores store-and-forward.
  always_comb begin
    count_next   = fifo_count;
    pkt_next     = pkt_count;
    release_next = release_mode;
    case ({wr_en, rd_en})
      2'b10:   count_next = fifo_count + CNT_ONE;
      2'b01:   count_next = fifo_count - CNT_ONE;
      default: count_next = fifo_count;
    endcase
    case ({wr_last, rd_last})
      2'b10:   pkt_next = pkt_count + CNT_ONE;
      2'b01:   pkt_next = pkt_count - CNT_ONE;
      default: pkt_next = pkt_count;
    endcase
    if ((count_next == FULL_CNT) && (pkt_next == '0)) begin
      release_next = 1'b1;
    end
    if (rd_last) begin
      release_next = 1'b0;
    end
  end

  always_ff @(posedge clk_line) begin
    if (clk_line_rst_high) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      pkt_count    <= '0;
      release_mode <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      fifo_count   <= count_next;
      pkt_count    <= pkt_next;
      release_mode <= release_next;
    end
  end

  always_ff @(posedge clk_line) begin
    if (wr_en) begin
      mem[wr_ptr] <= {stream_in_TLAST, stream_in_TDATA};
    end
  end

endmodule
